alu_serial_nbit: RTL and testbench
==================================

Name: alu_serial_nbit

Overview:
- Parametrised, bit-serial successor of the lab's 1-bit ALU cell.
- Processes WIDTH-bit operands LSB-first, one bit per clock, through a single 1-bit slice with a registered carry.
- Same F1/F0 function selection as the 1-bit cell.
- Start/busy/done handshake lets a controller or bench drive it as a multi-cycle execution unit.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- F  input  2  function select {F1,F0}: 00 AND, 01 OR, 10 XOR, 11 ADD.
- A  input  WIDTH  operand A, latched on accepted start.
- B  input  WIDTH  operand B, latched on accepted start.
- cin  input  1  carry-in for ADD, latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- Result  output  WIDTH  last completed result, held until next completion.
- Cout  output  1  carry-out of last ADD; 0 for logic ops.
- zero  output  1  high when the last completed Result == 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, Result=0, Cout=0, zero=1; counter, shift registers and carry cleared. Reset mid-RUN aborts the operation with no done. Outputs stay at reset values until the next completed operation.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k gives:
  - latch A, B and F into shift/op registers;
  - carry <= (F==11) ? cin : 0;
  - cnt <= 0; go to RUN.
- start=0: stay in IDLE.
- RUN (busy=1): each edge:
  - slice computes bit i from a_sh[0], b_sh[0], carry;
  - result bit shifts in at MSB of r_sh;
  - a_sh/b_sh shift right;
  - carry <= slice carry-out for ADD, else 0;
  - cnt++.
- After the WIDTH-th RUN edge (cnt==WIDTH-1 at that edge), go to DONE. Result register and Cout update on that same edge.
- DONE: done=1 for exactly one cycle (the cycle after edge k+WIDTH), then IDLE.
- Latency: done is high WIDTH+1 cycles after the start edge. Throughput: one operation per WIDTH+2 cycles.
- start while RUN or DONE: ignored, no queuing. A, B, F and cin changes during RUN have no effect.
- Result, Cout and zero change only on completion edges. They are stable from done until the next completion.
- Arithmetic: ADD result = (A+B+cin) mod 2^WIDTH; Cout = bit WIDTH of the sum. AND/OR/XOR are bitwise with Cout=0.
- zero is computed from the final Result value, registered together with Result.
- Counter wrap: cnt never exceeds WIDTH-1. It is cleared on start acceptance and on reset.

Decomposition:
- Package alu_pkg:
  - op-code localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11;
  - state encoding IDLE/RUN/DONE.
- Sub-module alu_bit_slice: combinational 1-bit ALU.
  - Inputs F, a, b, c. Outputs f, co.
  - co valid only for ADD, 0 otherwise.
  - Instantiated once inside alu_serial_nbit.

Test Plan (WIDTH=8):
- F=00, A=0xCA, B=0x0F, start 1 cycle: done pulses 9 cycles after start edge; Result=0x0A, Cout=0, zero=0; busy high exactly 8 cycles.
- Logic ops back-to-back:
  - F=01, A=0xA0, B=0x05: Result=0xA5.
  - then F=10, A=0xFF, B=0x0F: Result=0xF0.
  - Result holds 0xA5 throughout the second operation until its done.
- F=11, A=0xFF, B=0x01, cin=0: Result=0x00, Cout=1, zero=1. F=11, A=0x12, B=0x34, cin=1: Result=0x47, Cout=0.
- Start at edge k with A=0x01, B=0x01, F=11; hold start=1 and change A to 0x80 during RUN: exactly one done, Result=0x02, no second operation launched.
- Reset mid-operation: start ADD, assert rst_n=0 at cycle 4 of RUN:
  - busy, done and Cout drop to 0 immediately (async); Result=0x00, zero=1;
  - after release, no done until a new start;
  - new ADD 0x10+0x20 then gives 0x30.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the bit-serial ALU.
//   OP_*    : function-select codes for {F1,F0}
//   state_t : sequencer states of alu_serial_nbit
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU cell.
//   F  : function select {F1,F0} (AND, OR, XOR, ADD)
//   a  : operand A bit
//   b  : operand B bit
//   c  : carry-in (used by ADD only)
//   f  : result bit
//   co : carry-out, forced to 0 for the logic functions
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic [1:0] F,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       f,
    output logic       co
);

    always_comb begin
        f  = 1'b0;
        co = 1'b0;
        case (F)
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_XOR: f = a ^ b;
            OP_ADD: begin
                f  = a ^ b ^ c;
                co = (a & b) | (c & (a ^ b));
            end
            default: begin
                f  = 1'b0;
                co = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_nbit.sv
// alu_serial_nbit: bit-serial WIDTH-bit ALU built around one alu_bit_slice.
// Operands are consumed LSB-first, one bit per clock, with a registered carry.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : operation request, honoured only while idle
//   F      : function select {F1,F0}: 00 AND, 01 OR, 10 XOR, 11 ADD
//   A, B   : operands, captured when start is accepted
//   cin    : ADD carry-in, captured when start is accepted
//   busy   : high while bits are being processed
//   done   : one-cycle pulse once Result/Cout/zero hold the new result
//   Result : last completed result, held until the next completion
//   Cout   : carry-out of the last ADD (0 for logic functions)
//   zero   : high when the last completed Result is all zeros
module alu_serial_nbit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       F,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             zero
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   r_sh;
    logic [1:0]         op;
    logic               carry;

    logic               slice_f;
    logic               slice_co;
    logic [WIDTH-1:0]   r_next;

    alu_bit_slice u_slice (
        .F  (op),
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (carry),
        .f  (slice_f),
        .co (slice_co)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at
    // r_sh[0]; on the last edge this is the complete result.
    assign r_next = {slice_f, r_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
            Cout   <= 1'b0;
            zero   <= 1'b1;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            op     <= OP_AND;
            carry  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        op    <= F;
                        carry <= (F == OP_ADD) ? cin : 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    // slice_co is already 0 for the logic functions
                    carry <= slice_co;
                    if (cnt == CNT_LAST) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        Result <= r_next;
                        Cout   <= slice_co;
                        zero   <= (r_next == '0);
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_nbit.sv
// tb_alu_serial_nbit: directed and randomized checks of alu_serial_nbit
// (WIDTH=8) against an arithmetic reference model.
module tb_alu_serial_nbit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   F;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         Cout;
    logic         zero;

    int unsigned vectors;
    int unsigned miscompares;

    alu_serial_nbit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .F      (F),
        .A      (A),
        .B      (B),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Cout   (Cout),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry_out, result} from plain arithmetic on the operands.
    function automatic logic [W:0] model(input logic [1:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        case (f)
            2'd0:    r = {1'b0, a & b};
            2'd1:    r = {1'b0, a | b};
            2'd2:    r = {1'b0, a ^ b};
            default: r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Last completed result as the model sees it; Result must equal this
    // until the next done.
    logic [W:0] held;

    // Issue one operation and follow it to completion. With hold=1, start stays
    // high through RUN and A is changed mid-operation; neither may matter.
    task automatic run_op(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit hold);
        logic [W:0] exp;
        int n;
        int busy_cycles;
        exp = model(f, a, b, c);
        @(negedge clk);
        F = f; A = a; B = b; cin = c; start = 1'b1;
        @(negedge clk);                   // cycle 1 after the start edge
        if (!hold) start = 1'b0;
        F = ~f; B = ~b; cin = ~c;         // operands must already be captured
        n = 1;
        busy_cycles = 0;
        while (!done && n < 20) begin
            if (busy) busy_cycles++;
            chk("result_held", {23'd0, Result}, {23'd0, held[W-1:0]});
            if (hold && n == 3) A = 8'h80;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("latency", n, W + 1);
        chk("busy_cycles", busy_cycles, W);
        chk("result", {24'd0, Result}, {24'd0, exp[W-1:0]});
        chk("cout", {31'd0, Cout}, {31'd0, exp[W]});
        chk("zero", {31'd0, zero}, {31'd0, (exp[W-1:0] == '0)});
        held = exp;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        held = '0;
        rst_n = 1'b0; start = 1'b0; F = 2'b00; A = '0; B = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, Result}, 32'd0);
        chk("rst_cout", {31'd0, Cout}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;

        // Directed operations
        run_op(2'b00, 8'hCA, 8'h0F, 1'b0, 1'b0);
        run_op(2'b01, 8'hA0, 8'h05, 1'b0, 1'b0);
        run_op(2'b10, 8'hFF, 8'h0F, 1'b0, 1'b0);   // back-to-back, Result holds 0xA5
        run_op(2'b11, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(2'b11, 8'h12, 8'h34, 1'b1, 1'b0);
        run_op(2'b01, 8'h00, 8'h00, 1'b1, 1'b0);   // cin ignored for logic ops

        // start held through RUN with A changing: exactly one operation
        run_op(2'b11, 8'h01, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < W + 4; i++) begin
            chk("no_relaunch_busy", {31'd0, busy}, 32'd0);
            chk("no_relaunch_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end

        // Leave a non-zero result with Cout=1, then abort an ADD mid-RUN
        run_op(2'b11, 8'hF0, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        F = 2'b11; A = 8'h55; B = 8'h66; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);        // cycle 4 of RUN
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_cout", {31'd0, Cout}, 32'd0);
        chk("abort_result", {24'd0, Result}, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        held = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        run_op(2'b11, 8'h10, 8'h20, 1'b0, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(3)), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
